// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: access-size encodings,
// the responder FSM state type and the byte-lane strobe generator.
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Byte-lane write strobes for a store of the given size at byte offset off.
    // Misaligned halfword/word offsets never reach the array (error path).
    function automatic logic [3:0] byte_strobe(input logic [1:0] size,
                                               input logic [1:0] off);
        logic [3:0] be;
        be = '0;
        case (size)
            SIZE_B:  be = 4'b0001 << off;
            SIZE_H:  be = 4'b0011 << off;
            SIZE_W:  be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// ----------------------------------------------------------------------------
// dmem_bank
// Synchronous single-port 32-bit word array with per-byte write enables and a
// registered read port. No reset: contents persist across responder resets.
//   clk_i    clock
//   addr_i   word index
//   be_i     byte-lane write enables (bit i writes wdata_i[8i+7:8i])
//   wdata_i  write data
//   rdata_o  word read on the previous rising edge
// ----------------------------------------------------------------------------
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [3:0]                     be_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core's data port. Accepts one load/store at a
// time, inserts WAIT_STATES idle cycles, performs the byte-lane store or the
// load extract/extend, and returns a registered response.
//   clk, rst (async, active-low)
//   req_valid/req_ready  request handshake (req_ready registered, high in IDLE)
//   req_we, req_addr, req_size, req_unsigned, req_wdata  request fields
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              misaligned, out-of-range or illegal-size access
// ----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic          accept;
    logic          acc_err;
    logic [AW-1:0] bank_addr;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_ext;

    assign accept = req_valid && ready_q;

    assign acc_err = (size_q == SIZE_H && addr_q[0])
                  || (size_q == SIZE_W && addr_q[1:0] != 2'b00)
                  || (size_q == 2'b11)
                  || ({2'b00, addr_q[31:2]} >= DEPTH_L);

    // The bank read is registered: in IDLE it is fed the live request address
    // so the word is already in bank_rdata by the time ACCESS is reached, even
    // with zero wait states.
    assign bank_addr = (state_q == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign bank_be   = (state_q == ACCESS && we_q && !acc_err)
                     ? byte_strobe(size_q, addr_q[1:0]) : '0;

    always_comb begin
        bank_wdata = wdata_q;
        case (size_q)
            SIZE_B:  bank_wdata = {4{wdata_q[7:0]}};
            SIZE_H:  bank_wdata = {2{wdata_q[15:0]}};
            default: bank_wdata = wdata_q;
        endcase
    end

    always_comb begin
        lane_b   = bank_rdata[7:0];
        lane_h   = addr_q[1] ? bank_rdata[31:16] : bank_rdata[15:0];
        load_ext = '0;
        case (addr_q[1:0])
            2'd0:    lane_b = bank_rdata[7:0];
            2'd1:    lane_b = bank_rdata[15:8];
            2'd2:    lane_b = bank_rdata[23:16];
            default: lane_b = bank_rdata[31:24];
        endcase
        case (size_q)
            SIZE_B:  load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SIZE_H:  load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            SIZE_W:  load_ext = bank_rdata;
            default: load_ext = '0;
        endcase
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk_i   (clk),
        .addr_i  (bank_addr),
        .be_i    (bank_be),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                err_d   = acc_err;
                rdata_d = (acc_err || we_q) ? '0 : load_ext;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench: instance A (WAIT_STATES = 2) runs a table of load/store
// vectors plus backpressure and reset-mid-WAIT sequences; instance B
// (WAIT_STATES = 0) covers reset values and single-cycle latency.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_we, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    logic        sel_b;
    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    int checks = 0;
    int errors = 0;

    assign cur_ready = sel_b ? req_ready_b : req_ready_a;
    assign cur_valid = sel_b ? rsp_valid_b : rsp_valid_a;
    assign cur_err   = sel_b ? rsp_err_b   : rsp_err_a;
    assign cur_rdata = sel_b ? rsp_rdata_b : rsp_rdata_a;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string n, input logic we, input logic [31:0] a,
                                input logic [1:0] s, input logic u, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.size = s; v.uns = u;
        v.wdata = wd; v.exp_rd = erd; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; lat counts edges from
    // the accept edge to the edge that raised rsp_valid.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        n   = 0;
        rd  = '1;
        er  = 1'b1;
        lat = -1;
        while (!cur_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cur_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: req_ready 0 after %0d cycles, expected 1", n);
            return;
        end
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
        rsp_ready = 1'b1;
        if (sel_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        // scramble request fields after accept: the DUT must use latched copies
        req_we = ~we; req_addr = '1; req_size = 2'b11; req_unsigned = ~uns; req_wdata = ~wd;
        lat = 0;
        while (!cur_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cur_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid 0 after %0d cycles, expected 1", lat);
            return;
        end
        rd = cur_rdata;
        er = cur_err;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        rst = 1'b0; sel_b = 1'b1; rsp_ready = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_addr = '0; req_size = SIZE_W; req_unsigned = 1'b0; req_wdata = '0;

        // ---- reset values (WAIT_STATES = 0 instance, plus A) ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_b",  32'(req_ready_b), 32'h0);
        chk("rst_valid_b",  32'(rsp_valid_b), 32'h0);
        chk("rst_rdata_b",  rsp_rdata_b,      32'h0);
        chk("rst_err_b",    32'(rsp_err_b),   32'h0);
        chk("rst_ready_a",  32'(req_ready_a), 32'h0);
        chk("rst_valid_a",  32'(rsp_valid_a), 32'h0);
        rst = 1'b1;
        #1;
        chk("ready_b_pre_edge", 32'(req_ready_b), 32'h0);
        @(posedge clk); #1;
        chk("ready_b_post_edge", 32'(req_ready_b), 32'h1);

        // ---- zero-wait-state latency ----
        txn(1'b1, 32'h40, SIZE_W, 1'b0, 32'h5A5A1234, rd, er, lat);
        chk("b_st_rdata", rd, 32'h0);
        chk("b_st_err",   32'(er), 32'h0);
        chk("b_st_lat",   32'(lat), 32'd1);
        txn(1'b0, 32'h40, SIZE_W, 1'b0, 32'h0, rd, er, lat);
        chk("b_ld_rdata", rd, 32'h5A5A1234);
        chk("b_ld_lat",   32'(lat), 32'd1);
        txn(1'b0, 32'h1000, SIZE_B, 1'b1, 32'h0, rd, er, lat);
        chk("b_oor_err",   32'(er), 32'h1);
        chk("b_oor_rdata", rd, 32'h0);

        // ---- vector table on A (WAIT_STATES = 2) ----
        sel_b = 1'b0;
        vt.push_back(mk("st_w_10",     1, 32'h10,   SIZE_W, 0, 32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk("ld_w_10",     0, 32'h10,   SIZE_W, 0, 32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk("st_w_10b",    1, 32'h10,   SIZE_W, 0, 32'h11223344, 32'h0,        0));
        vt.push_back(mk("st_b_13",     1, 32'h13,   SIZE_B, 0, 32'h00000080, 32'h0,        0));
        vt.push_back(mk("ld_bs_13",    0, 32'h13,   SIZE_B, 0, 32'h0,        32'hFFFFFF80, 0));
        vt.push_back(mk("ld_bu_13",    0, 32'h13,   SIZE_B, 1, 32'h0,        32'h00000080, 0));
        vt.push_back(mk("ld_w_10c",    0, 32'h10,   SIZE_W, 0, 32'h0,        32'h80223344, 0));
        vt.push_back(mk("st_w_20",     1, 32'h20,   SIZE_W, 0, 32'hCAFEF00D, 32'h0,        0));
        vt.push_back(mk("st_h_21_mis", 1, 32'h21,   SIZE_H, 0, 32'h0000AAAA, 32'h0,        1));
        vt.push_back(mk("ld_w_20",     0, 32'h20,   SIZE_W, 0, 32'h0,        32'hCAFEF00D, 0));
        vt.push_back(mk("ld_w_22_mis", 0, 32'h22,   SIZE_W, 0, 32'h0,        32'h0,        1));
        vt.push_back(mk("ld_w_1000",   0, 32'h1000, SIZE_W, 0, 32'h0,        32'h0,        1));
        vt.push_back(mk("st_w_ffc",    1, 32'hFFC,  SIZE_W, 0, 32'h0BADCAFE, 32'h0,        0));
        vt.push_back(mk("ld_w_ffc",    0, 32'hFFC,  SIZE_W, 0, 32'h0,        32'h0BADCAFE, 0));
        vt.push_back(mk("st_h_22",     1, 32'h22,   SIZE_H, 0, 32'h1234ABCD, 32'h0,        0));
        vt.push_back(mk("ld_w_20b",    0, 32'h20,   SIZE_W, 0, 32'h0,        32'hABCDF00D, 0));
        vt.push_back(mk("ld_hs_22",    0, 32'h22,   SIZE_H, 0, 32'h0,        32'hFFFFABCD, 0));
        vt.push_back(mk("ld_hu_22",    0, 32'h22,   SIZE_H, 1, 32'h0,        32'h0000ABCD, 0));
        vt.push_back(mk("ld_hs_20",    0, 32'h20,   SIZE_H, 0, 32'h0,        32'hFFFFF00D, 0));
        vt.push_back(mk("ld_bu_21",    0, 32'h21,   SIZE_B, 1, 32'h0,        32'h000000F0, 0));
        vt.push_back(mk("ld_bs_20",    0, 32'h20,   SIZE_B, 0, 32'h0,        32'h0000000D, 0));
        vt.push_back(mk("st_ill_20",   1, 32'h20,   2'b11,  0, 32'hFFFFFFFF, 32'h0,        1));
        vt.push_back(mk("ld_ill_20",   0, 32'h20,   2'b11,  0, 32'h0,        32'h0,        1));
        vt.push_back(mk("ld_w_20c",    0, 32'h20,   SIZE_W, 0, 32'h0,        32'hABCDF00D, 0));
        vt.push_back(mk("st_b_10",     1, 32'h10,   SIZE_B, 0, 32'hFFFFFF55, 32'h0,        0));
        vt.push_back(mk("ld_w_10d",    0, 32'h10,   SIZE_W, 0, 32'h0,        32'h80223355, 0));
        vt.push_back(mk("ld_bs_12",    0, 32'h12,   SIZE_B, 0, 32'h0,        32'h00000022, 0));
        vt.push_back(mk("st_h_10",     1, 32'h10,   SIZE_H, 0, 32'h00008001, 32'h0,        0));
        vt.push_back(mk("ld_hu_10",    0, 32'h10,   SIZE_H, 1, 32'h0,        32'h00008001, 0));
        vt.push_back(mk("ld_bs_11",    0, 32'h11,   SIZE_B, 0, 32'h0,        32'hFFFFFF80, 0));

        foreach (vt[i]) begin
            txn(vt[i].we, vt[i].addr, vt[i].size, vt[i].uns, vt[i].wdata, rd, er, lat);
            chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
            chk({vt[i].name, "_err"}, 32'(er), 32'(vt[i].exp_err));
            chk({vt[i].name, "_lat"}, 32'(lat), 32'd3);
        end

        // ---- backpressure: response held while rsp_ready = 0 ----
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_size = SIZE_W; req_unsigned = 1'b0;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_addr = '1;
        chk("bp_ready_after_accept", 32'(req_ready_a), 32'h0);
        n = 0;
        while (!rsp_valid_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", 32'(n), 32'd3);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid_a), 32'h1);
            chk("bp_rdata", rsp_rdata_a, 32'h80228001);
            chk("bp_ready", 32'(req_ready_a), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", 32'(rsp_valid_a), 32'h0);
        chk("bp_ready_back", 32'(req_ready_a), 32'h1);

        // ---- reset during WAIT of a store ----
        txn(1'b1, 32'h30, SIZE_W, 1'b0, 32'h01020304, rd, er, lat);
        chk("rw_setup_err", 32'(er), 32'h0);
        req_we = 1'b1; req_addr = 32'h30; req_size = SIZE_W; req_wdata = 32'hFFFFFFFF;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(posedge clk); #1;
        chk("rw_in_wait_valid", 32'(rsp_valid_a), 32'h0);
        rst = 1'b0;
        #1;
        chk("rw_rst_ready", 32'(req_ready_a), 32'h0);
        chk("rw_rst_valid", 32'(rsp_valid_a), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_rst_valid_hold", 32'(rsp_valid_a), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rw_ready_after_rst", 32'(req_ready_a), 32'h1);
        txn(1'b0, 32'h30, SIZE_W, 1'b0, 32'h0, rd, er, lat);
        chk("rw_word_unchanged", rd, 32'h01020304);
        txn(1'b0, 32'h20, SIZE_W, 1'b0, 32'h0, rd, er, lat);
        chk("rw_array_survives_rst", rd, 32'hABCDF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
